// File: rtl/imuldiv_div_req_queue.sv
// Two-entry request FIFO between the multiply/divide front end and the iterative divider.
// The divide-by-zero flag is computed on entry. Optional same-cycle bypass is enabled by IMULDIV_DIVREQ_BYPASS_EN.
module imuldiv_div_req_queue (
   input  logic        clk,
   input  logic        reset,
   input  logic        enq_msg_fn,
   input  logic [31:0] enq_msg_a,
   input  logic [31:0] enq_msg_b,
   input  logic        enq_val,
   output logic        enq_rdy,
   output logic        deq_msg_fn,
   output logic [31:0] deq_msg_a,
   output logic [31:0] deq_msg_b,
   output logic        deq_msg_dbz,
   output logic        deq_val,
   input  logic        deq_rdy,
   output logic [1:0]  count
);

   typedef struct packed {
      logic        fn;
      logic [31:0] a;
      logic [31:0] b;
      logic        dbz;
   } entry_t;

   entry_t      mem_q [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;

   entry_t      enq_entry;
   entry_t      head;
   entry_t      deq_entry;
   logic        enq_fire;
   logic        wr_en;
   logic        rd_en;

   always_comb begin
      enq_entry.fn  = enq_msg_fn;
      enq_entry.a   = enq_msg_a;
      enq_entry.b   = enq_msg_b;
      enq_entry.dbz = (enq_msg_b == 32'd0);
   end

   assign head     = mem_q[rd_ptr_q];
   assign enq_rdy  = (count_q != 2'd2);
   assign enq_fire = enq_val && enq_rdy;
   assign rd_en    = (count_q != 2'd0) && deq_rdy;

`ifdef IMULDIV_DIVREQ_BYPASS_EN
   logic bypass;
   // An empty queue forwards the incoming request directly to the divider. It is stored only if the divider stalls.
   assign bypass    = (count_q == 2'd0) && enq_val;
   assign deq_val   = (count_q != 2'd0) || enq_val;
   assign deq_entry = bypass ? enq_entry : head;
   assign wr_en     = enq_fire && !(bypass && deq_rdy);
`else
   assign deq_val   = (count_q != 2'd0);
   assign deq_entry = head;
   assign wr_en     = enq_fire;
`endif

   assign deq_msg_fn  = deq_entry.fn;
   assign deq_msg_a   = deq_entry.a;
   assign deq_msg_b   = deq_entry.b;
   assign deq_msg_dbz = deq_entry.dbz;
   assign count       = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q ^ wr_en;
      rd_ptr_d = rd_ptr_q ^ rd_en;
      count_d  = count_q;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= enq_entry;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: doc/imuldiv_div_req_queue.md
IMULDIV_DIV_REQ_QUEUE -- requirements
Module: imuldiv_DivReqQueue

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 SHALL have port: enq_msg_fn  input  1  divide function (0 = signed div/rem, 1 = unsigned), passed through unchanged.
REQ-004 SHALL have port: enq_msg_a  input  32  dividend.
REQ-005 SHALL have port: enq_msg_b  input  32  divisor.
REQ-006 SHALL have port: enq_val  input  1  upstream request valid.
REQ-007 SHALL have port: enq_rdy  output  1  queue can accept a request.
REQ-008 SHALL have port: deq_msg_fn  output  1  head-entry function.
REQ-009 SHALL have port: deq_msg_a  output  32  head-entry dividend.
REQ-010 SHALL have port: deq_msg_b  output  32  head-entry divisor.
REQ-011 SHALL have port: deq_msg_dbz  output  1  head-entry divide-by-zero flag.
REQ-012 SHALL have port: deq_val  output  1  head entry valid; drives the iterative divider's request valid.
REQ-013 SHALL have port: deq_rdy  input  1  driven by the divider's request ready.
REQ-014 SHALL have port: count  output  2  number of stored entries (0..2).

Function
REQ-015 SHALL implement a 2-entry circular FIFO: 1-bit write pointer, 1-bit read pointer, 2-bit occupancy count.
REQ-016 SHALL perform an enqueue on a rising edge when enq_val && enq_rdy, storing {fn, a, b, dbz} at the write pointer and toggling the write pointer.
REQ-017 SHALL compute dbz = (enq_msg_b == 32'd0) at enqueue time and store it with the entry.
REQ-018 SHALL perform a dequeue on a rising edge when deq_val && deq_rdy, toggling the read pointer.
REQ-019 SHALL drive enq_rdy = (count != 2); when full, enq_rdy SHALL be 0 even if deq_rdy = 1 (no full-queue pass-through).
REQ-020 SHALL drive deq_val = (count != 0), except as modified by REQ-030.
REQ-021 SHALL drive deq_msg_* combinationally from the entry at the read pointer.
REQ-022 SHALL update count as follows: +1 on enqueue only, -1 on dequeue only, unchanged on simultaneous enqueue and dequeue (count = 1 case).
REQ-023 SHALL wrap both pointers modulo 2 with no lost or duplicated entries; entries leave in strict arrival order.
REQ-024 SHALL give a stored entry a minimum enqueue-to-dequeue latency of 1 cycle (without REQ-030).
REQ-025 SHALL hold deq_msg_* stable while deq_val = 1 and deq_rdy = 0, including while the divider is computing.
REQ-026 SHALL NOT combinationally depend on deq_rdy for enq_rdy or deq_val (no combinational loop through the divider handshake).

Reset
REQ-027 SHALL, while reset = 0 (asynchronously), clear both pointers, count = 0 and all storage = 0; outputs SHALL then be enq_rdy = 1, deq_val = 0, deq_msg_* = 0, count = 0.
REQ-028 SHALL treat reset asserted mid-operation as discarding all queued entries; no dequeue SHALL occur in the cycle reset deasserts unless a new enqueue has completed first.

Configuration
REQ-029 SHALL use the macro IMULDIV_DIVREQ_BYPASS_EN to compile the bypass path in or out.
REQ-030 SHALL, with IMULDIV_DIVREQ_BYPASS_EN defined, use bypass when count = 0 and enq_val = 1: deq_val = 1 and deq_msg_* = enq message (dbz computed live); if deq_rdy = 1, nothing is written and count stays 0; if deq_rdy = 0, the entry is enqueued normally.
REQ-031 SHALL, without IMULDIV_DIVREQ_BYPASS_EN, behave exactly as REQ-020/REQ-024, with the enq-to-deq path purely registered.

Verification
REQ-032 SHALL pass: after reset, enqueue {fn=0, a=100, b=7}, deq_rdy = 1 -> next cycle deq_val = 1 with a = 100, b = 7, dbz = 0; count goes 1 -> 0 after dequeue.
REQ-033 SHALL pass: deq_rdy = 0, enqueue a=1, a=2, then attempt a=3 -> count = 2, enq_rdy = 0, a=3 not accepted; release deq_rdy -> dequeues a=1 then a=2 in order.
REQ-034 SHALL pass: count = 1 (a=5) with simultaneous enqueue a=6 and dequeue -> count stays 1 and next head a = 6; repeat 4 times to check pointer wrap.
REQ-035 SHALL pass: enqueue b = 0 -> deq_msg_dbz = 1; enqueue b = 32'hFFFFFFFF -> dbz = 0.
REQ-036 SHALL pass: count = 2, reset pulsed low mid-cycle -> immediately deq_val = 0, count = 0, enq_rdy = 1.
REQ-037 SHALL pass with IMULDIV_DIVREQ_BYPASS_EN: empty queue, enq_val = 1 with a=9, deq_rdy = 1 -> same cycle deq_val = 1, deq_msg_a = 9, count remains 0.
